cv32e40s_obi_data_responder: RTL and testbench
==============================================

# cv32e40s_obi_data_responder

Bus-side OBI data responder: the subordinate end of the LSU data interface. It accepts OBI data requests and queues up to DEPTH of them in order. It drives each one onto a simple granted SRAM-style memory port, or rejects it with an error if its address is outside the configured window. It returns one in-order response per request. It backs a tightly-coupled data RAM or peripheral region and is the counterpart of the core-side LSU response path.

## Interface
- DEPTH, 2: maximum outstanding requests (accepted, not yet responded); must be ≥ 1.
- ADDR_BASE, 32'h0000_0000: first byte address of the window.
- ADDR_SIZE, 32'h0001_0000: window size in bytes; must be non-zero.
- CNT_WIDTH, $clog2(DEPTH+1): outstanding counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_i  in  1  OBI request valid.
- gnt_o  out  1  OBI grant.
- addr_i  in  32  byte address.
- we_i  in  1  1 = store.
- be_i  in  4  byte enables.
- wdata_i  in  32  store data.
- rvalid_o  out  1  response valid; no rready, so the consumer always accepts.
- rdata_o  out  32  load data; 0 for stores and errors.
- err_o  out  1  bus error response.
- mem_req_o  out  1  memory request.
- mem_gnt_i  in  1  memory grant.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  32  addr_i minus ADDR_BASE (byte offset).
- mem_be_o  out  4  memory byte enables.
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  read data, valid the cycle after a mem_req_o && mem_gnt_i handshake.
- outstnd_cnt_o  out  CNT_WIDTH  current outstanding count.

## Operation
- Accept: when req_i && gnt_o, push {addr offset, we, be, wdata, oob} into the request FIFO.
  - oob = ((addr_i − ADDR_BASE) mod 2^32) ≥ ADDR_SIZE. Compare as unsigned 32-bit, so addresses below the base wrap around and are out of window.
- Request FIFO: DEPTH entries, in order. Push and pop in the same cycle is legal.
- Head processing, at most one retire per cycle:
  - oob = 0: drive mem_req_o = 1 with the head's fields. The head retires on mem_gnt_i. While mem_gnt_i = 0, hold all mem_* outputs stable.
  - oob = 1: no memory access (mem_req_o = 0). The head retires unconditionally.
- Response stage: one registered entry {valid, we, oob}, loaded from every retiring head. The next cycle it produces:
  - rvalid_o = 1 and err_o = oob;
  - rdata_o = mem_rdata_i if (!we && !oob), else 32'h0.
- Counter cnt_q: +1 on accept, −1 on rvalid_o. Both in one cycle leaves it unchanged.
- gnt_o = (cnt_q < DEPTH). It is registered-count based and does not depend on req_i or on the current cycle's rvalid_o.
- Responses are strictly in acceptance order; error responses never overtake earlier memory responses.

## Timing
- Reset values: gnt_o = 1, rvalid_o = 0, rdata_o = 0, err_o = 0, mem_req_o = 0, outstnd_cnt_o = 0. FIFO and response stage are empty.
- Minimum latency: accept in cycle N; mem_req_o in N+1 (granted); rvalid_o in N+2. Error requests also respond in N+2.
- Throughput: one response per cycle when mem_gnt_i stays high.
- Full (cnt_q == DEPTH): gnt_o = 0 for the whole cycle, even if a response completes in that cycle. gnt_o returns the cycle after cnt_q drops.
- Empty FIFO: mem_req_o = 0; mem_* data outputs are don't-care.
- Memory stall: each cycle with mem_gnt_i = 0 adds one cycle to the head's latency and to every younger request's latency.
- rst_n asserted mid-operation: all queued and in-flight requests are discarded, with no responses. Outputs immediately take their reset values.

## Structure
- cv32e40s_pkg gets obi_rsp_entry_t = {addr[31:0], we, be[3:0], wdata[31:0], oob}, shared by the FIFO and any bench model.
- One sub-module: cv32e40s_obi_responder_fifo.
  - Parameterised DEPTH.
  - Push/pop/full/empty; head on a combinational output.
  - Asynchronous, active-low reset.
- Window check, counter and response stage stay in the top module.

## Test plan
- Single load at ADDR_BASE+4, mem_gnt_i = 1, mem_rdata_i = 32'hDEAD_BEEF → mem_req_o in N+1 with mem_addr_o = 4; rvalid_o in N+2 with rdata_o = 32'hDEAD_BEEF, err_o = 0.
- Store to ADDR_BASE+ADDR_SIZE (one past the end), be_i = 4'hF → no mem_req_o; rvalid_o in N+2 with err_o = 1, rdata_o = 0. The same test at ADDR_BASE+ADDR_SIZE−1 gives err_o = 0.
- DEPTH = 2, mem_gnt_i = 0, req_i held high → exactly 2 grants, then gnt_o = 0 and outstnd_cnt_o = 2. Release mem_gnt_i → 2 in-order responses; gnt_o = 1 the cycle after the first rvalid_o.
- Back-to-back sequence load (in window), load (oob), store (in window) with mem_gnt_i = 1 → three consecutive rvalid_o cycles, err_o = 0, 1, 0.
- mem_gnt_i low for 3 cycles on a load → mem_* outputs held stable; rvalid_o exactly one cycle after the grant.
- rst_n pulsed low while 2 requests are outstanding → rvalid_o and mem_req_o drop immediately; after release gnt_o = 1, outstnd_cnt_o = 0, and no stale responses appear.

Source files
------------

// File: rtl/cv32e40s_pkg.sv
//------------------------------------------------------------------------------
// Module   : cv32e40s_pkg
// Brief    : Shared types and helpers for the OBI data responder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cv32e40s_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        oob;
    } obi_rsp_entry_t;

    // Unsigned wrap-around compare: addresses below the base land far above the window.
    function automatic logic addr_oob(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] size);
        return (addr - base) >= size;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cv32e40s_obi_responder_fifo.sv
//------------------------------------------------------------------------------
// Module   : cv32e40s_obi_responder_fifo
// Brief    : In-order request FIFO with combinational head output.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cv32e40s_obi_responder_fifo
    import cv32e40s_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push,
    input  obi_rsp_entry_t i_data,
    input  logic           i_pop,
    output logic           o_full,
    output logic           o_empty,
    output obi_rsp_entry_t o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    obi_rsp_entry_t r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cv32e40s_obi_data_responder.sv
//------------------------------------------------------------------------------
// Module   : cv32e40s_obi_data_responder
// Brief    : OBI data subordinate driving a granted SRAM-style memory port.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cv32e40s_obi_data_responder
    import cv32e40s_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
    parameter int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic [31:0]          addr_i,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic [31:0]          mem_addr_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_wdata_o,
    input  logic [31:0]          mem_rdata_i,
    output logic [CNT_WIDTH-1:0] outstnd_cnt_o
);

    obi_rsp_entry_t       w_push_entry;
    obi_rsp_entry_t       w_head;
    logic                 w_accept;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic                 w_retire;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_rsp_valid;
    logic                 r_rsp_we;
    logic                 r_rsp_oob;

    assign w_accept = req_i && gnt_o;

    always_comb begin
        w_push_entry       = '0;
        w_push_entry.addr  = addr_i - ADDR_BASE;
        w_push_entry.we    = we_i;
        w_push_entry.be    = be_i;
        w_push_entry.wdata = wdata_i;
        w_push_entry.oob   = addr_oob(addr_i, ADDR_BASE, ADDR_SIZE);
    end

    cv32e40s_obi_responder_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept && !w_fifo_full),
        .i_data  (w_push_entry),
        .i_pop   (w_retire),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // Out-of-window heads retire without touching memory; the rest wait for the grant.
    assign mem_req_o   = !w_fifo_empty && !w_head.oob;
    assign w_retire    = !w_fifo_empty && (w_head.oob || mem_gnt_i);
    assign mem_we_o    = w_head.we;
    assign mem_addr_o  = w_head.addr;
    assign mem_be_o    = w_head.be;
    assign mem_wdata_o = w_head.wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_oob   <= 1'b0;
        end else begin
            r_rsp_valid <= w_retire;
            r_rsp_we    <= w_head.we;
            r_rsp_oob   <= w_head.oob;
        end
    end

    assign rvalid_o = r_rsp_valid;
    assign err_o    = r_rsp_valid && r_rsp_oob;
    assign rdata_o  = (r_rsp_valid && !r_rsp_we && !r_rsp_oob) ? mem_rdata_i : 32'h0;

    // Counts FIFO entries plus the response stage, so the FIFO itself never overflows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && !rvalid_o) begin
            r_cnt <= r_cnt + 1'b1;
        end else if (!w_accept && rvalid_o) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign gnt_o         = (r_cnt < CNT_WIDTH'(DEPTH));
    assign outstnd_cnt_o = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40s_obi_data_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_cv32e40s_obi_data_responder
// Brief    : Self-checking bench with response scoreboard for the OBI responder.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cv32e40s_obi_data_responder;

    localparam int unsigned DEPTH     = 2;
    localparam logic [31:0] ADDR_BASE = 32'h1000_0000;
    localparam logic [31:0] ADDR_SIZE = 32'h0000_1000;
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req_i = 1'b0;
    logic                 gnt_o;
    logic [31:0]          addr_i = '0;
    logic                 we_i = 1'b0;
    logic [3:0]           be_i = '0;
    logic [31:0]          wdata_i = '0;
    logic                 rvalid_o;
    logic [31:0]          rdata_o;
    logic                 err_o;
    logic                 mem_req_o;
    logic                 mem_gnt_i = 1'b0;
    logic                 mem_we_o;
    logic [31:0]          mem_addr_o;
    logic [3:0]           mem_be_o;
    logic [31:0]          mem_wdata_o;
    logic [31:0]          mem_rdata_i;
    logic [CNT_WIDTH-1:0] outstnd_cnt_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic rsp_log[$];

    cv32e40s_obi_data_responder #(
        .DEPTH     (DEPTH),
        .ADDR_BASE (ADDR_BASE),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_be_o      (mem_be_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_rdata_i   (mem_rdata_i),
        .outstnd_cnt_o (outstnd_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_fn(input logic [31:0] off);
        return 32'hDEAD_BEEF ^ (off - 32'd4);
    endfunction

    // Memory model: read data valid only the cycle after a handshake.
    always @(posedge clk) begin
        if (mem_req_o && mem_gnt_i) mem_rdata_i <= data_fn(mem_addr_o);
        else                        mem_rdata_i <= 32'h0BAD_0BAD;
    end

    // Scoreboard: pop/compare on every response, push on every accepted request.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rvalid_o) begin
                rsp_log.push_back(err_o);
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected_rvalid: got rvalid err=%0b rdata=%h, expected no response", err_o, rdata_o);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (err_o !== e.err || rdata_o !== e.rdata) begin
                        n_fail++;
                        $display("FAIL sb_response: got err=%0b rdata=%h, expected err=%0b rdata=%h", err_o, rdata_o, e.err, e.rdata);
                    end
                end
            end
            if (req_i && gnt_o) begin
                exp_t e;
                logic [31:0] off;
                off     = addr_i - ADDR_BASE;
                e.err   = (off >= ADDR_SIZE);
                e.rdata = (!we_i && !e.err) ? data_fn(off) : 32'h0;
                sb.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a request until granted; returns 1 ns after the accepting edge with req_i low.
    task automatic send(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        logic got;
        got     = 1'b0;
        req_i   = 1'b1;
        addr_i  = addr;
        we_i    = we;
        be_i    = 4'hF;
        wdata_i = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (gnt_o) got = 1'b1;
            tick();
            if (got) break;
        end
        req_i = 1'b0;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL send_grant_timeout: got no grant for addr %h, expected grant within 20 cycles", addr);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b0 || rdata_o !== 32'h0 || err_o !== 1'b0 ||
            mem_req_o !== 1'b0 || outstnd_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got gnt=%0b rvalid=%0b rdata=%h err=%0b mem_req=%0b cnt=%0d, expected 1 0 0 0 0 0",
                     gnt_o, rvalid_o, rdata_o, err_o, mem_req_o, outstnd_cnt_o);
        end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_load();
        mem_gnt_i = 1'b1;
        send(ADDR_BASE + 32'd4, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'd4 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF) begin
            n_fail++;
            $display("FAIL load_mem_req: got req=%0b addr=%h we=%0b be=%h, expected 1 00000004 0 f",
                     mem_req_o, mem_addr_o, mem_we_o, mem_be_o);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rvalid_o !== 1'b1 || rdata_o !== 32'hDEAD_BEEF || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL load_response: got rvalid=%0b rdata=%h err=%0b, expected 1 deadbeef 0", rvalid_o, rdata_o, err_o);
        end
        tick();
    endtask

    task automatic test_window_store(input logic [31:0] addr, input logic exp_err);
        mem_gnt_i = 1'b1;
        send(addr, 1'b1, 32'hCAFE_0001);
        @(negedge clk);
        n_checks++;
        if (mem_req_o !== !exp_err || (!exp_err && (mem_we_o !== 1'b1 || mem_wdata_o !== 32'hCAFE_0001))) begin
            n_fail++;
            $display("FAIL store_mem_req(%h): got req=%0b we=%0b wdata=%h, expected req=%0b", addr, mem_req_o, mem_we_o, mem_wdata_o, !exp_err);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rvalid_o !== 1'b1 || err_o !== exp_err || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL store_response(%h): got rvalid=%0b err=%0b rdata=%h, expected 1 %0b 0", addr, rvalid_o, err_o, rdata_o, exp_err);
        end
        tick();
    endtask

    task automatic test_full();
        int acc;
        acc       = 0;
        mem_gnt_i = 1'b0;
        req_i     = 1'b1;
        we_i      = 1'b0;
        addr_i    = ADDR_BASE + 32'h8;
        for (int k = 0; k < 5; k++) begin
            logic took;
            @(negedge clk);
            took = req_i && gnt_o;
            if (took) acc++;
            tick();
            if (took) addr_i = addr_i + 32'd4;
        end
        @(negedge clk);
        n_checks++;
        if (acc != int'(DEPTH) || gnt_o !== 1'b0 || outstnd_cnt_o !== CNT_WIDTH'(DEPTH)) begin
            n_fail++;
            $display("FAIL full_grants: got grants=%0d gnt=%0b cnt=%0d, expected %0d 0 %0d", acc, gnt_o, outstnd_cnt_o, DEPTH, DEPTH);
        end
        tick();
        req_i     = 1'b0;
        mem_gnt_i = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 10 && !seen; k++) begin
                @(negedge clk);
                if (rvalid_o) seen = 1'b1;
                else tick();
            end
            n_checks++;
            if (!seen || gnt_o !== 1'b0) begin
                n_fail++;
                $display("FAIL full_first_rvalid: got seen=%0b gnt=%0b, expected rvalid with gnt 0", seen, gnt_o);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 1'b1 || rvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL full_regrant: got gnt=%0b rvalid=%0b, expected 1 1", gnt_o, rvalid_o);
        end
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        mem_gnt_i = 1'b1;
        rsp_log.delete();
        send(ADDR_BASE + 32'h10, 1'b0, 32'h0);
        send(ADDR_BASE - 32'd4,  1'b0, 32'h0);
        send(ADDR_BASE + 32'h20, 1'b1, 32'h1234_5678);
        repeat (8) tick();
        n_checks++;
        if (rsp_log.size() != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses, expected 3", rsp_log.size());
        end else if (rsp_log[0] !== 1'b0 || rsp_log[1] !== 1'b1 || rsp_log[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_err_order: got %0b%0b%0b, expected 010", rsp_log[0], rsp_log[1], rsp_log[2]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] a;
        logic        w;
        logic [3:0]  b;
        mem_gnt_i = 1'b0;
        send(ADDR_BASE + 32'h40, 1'b0, 32'h0);
        @(negedge clk);
        a = mem_addr_o;
        w = mem_we_o;
        b = mem_be_o;
        n_checks++;
        if (mem_req_o !== 1'b1 || a !== 32'h40) begin
            n_fail++;
            $display("FAIL stall_first_req: got req=%0b addr=%h, expected 1 00000040", mem_req_o, a);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 2) mem_gnt_i = 1'b1;
            @(negedge clk);
            n_checks++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== a || mem_we_o !== w || mem_be_o !== b || rvalid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got req=%0b addr=%h rvalid=%0b, expected 1 %h 0", k, mem_req_o, mem_addr_o, rvalid_o, a);
            end
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (rvalid_o !== 1'b1 || mem_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got rvalid=%0b mem_req=%0b, expected 1 0", rvalid_o, mem_req_o);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        mem_gnt_i = 1'b1;
        send(ADDR_BASE + 32'h80, 1'b0, 32'h0);
        send(ADDR_BASE + 32'h84, 1'b0, 32'h0);
        @(negedge clk);
        n_checks++;
        if (rvalid_o !== 1'b1 || mem_req_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got rvalid=%0b mem_req=%0b, expected 1 1", rvalid_o, mem_req_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rvalid_o !== 1'b0 || mem_req_o !== 1'b0 || gnt_o !== 1'b1 || outstnd_cnt_o !== '0 || rdata_o !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_async: got rvalid=%0b mem_req=%0b gnt=%0b cnt=%0d rdata=%h, expected 0 0 1 0 0",
                     rvalid_o, mem_req_o, gnt_o, outstnd_cnt_o, rdata_o);
        end
        sb.delete();
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        n_checks++;
        if (gnt_o !== 1'b1 || outstnd_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL rstmid_after: got gnt=%0b cnt=%0d, expected 1 0", gnt_o, outstnd_cnt_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_window_store(ADDR_BASE + ADDR_SIZE, 1'b1);
        test_window_store(ADDR_BASE + ADDR_SIZE - 32'd1, 1'b0);
        test_full();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drained: got %0d pending expectations, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
